// File: rtl/q_step_engine.sv
// One Q-learning step per request on a GRID x GRID grid-world: read Q(s,*), pick an action,
// move, read Q(s',*), compute the TD update and write Q(s,a) back to an external sync RAM.
module q_step_engine #(
  parameter int          DATA_WIDTH    = 16,
  parameter int          GRID          = 4,
  parameter int          STATE_WIDTH   = 4,
  parameter int          COUNTER_WIDTH = 16,
  parameter int          START_STATE   = 0,
  parameter int          GOAL_STATE    = 15,
  parameter int          REWARD_STEP   = -256,
  parameter int          REWARD_GOAL   = 2560,
  parameter int          ALPHA_SHIFT   = 2,
  parameter int          GAMMA_SHIFT   = 4,
  parameter int          EPSILON       = 26,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic [COUNTER_WIDTH-1:0] i_step,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_goal,
  output logic [STATE_WIDTH-1:0]   o_state,
  output logic                     o_mem_rd_en,
  output logic                     o_mem_wr_en,
  output logic [STATE_WIDTH+1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]    o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]    i_mem_rdata
);

  localparam int NS = GRID * GRID;
  localparam int CW = DATA_WIDTH + 2;
  localparam logic [STATE_WIDTH-1:0] START_S = STATE_WIDTH'(START_STATE);
  localparam logic [STATE_WIDTH-1:0] GOAL_S  = STATE_WIDTH'(GOAL_STATE);
  localparam logic signed [CW-1:0]   QMAX    = CW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [CW-1:0]   QMIN    = ~QMAX;
  localparam logic signed [CW-1:0]   RW_STEP = CW'(REWARD_STEP);
  localparam logic signed [CW-1:0]   RW_GOAL = CW'(REWARD_GOAL);

  typedef enum logic [2:0] {IDLE, RD_CUR, SELECT, RD_NEXT, CALC, WRITE, DONE} st_t;

  st_t                          st;
  logic [2:0]                   sub;
  logic [STATE_WIDTH-1:0]       cur_s, nxt_s, nxt_c, rd_s, start_s;
  logic [1:0]                   act, best, sel_a, cap_idx;
  logic [15:0]                  lfsr, lfsr_nx;
  logic                         fb, goal_r;
  logic signed [DATA_WIDTH-1:0] q   [4];
  logic signed [DATA_WIDTH-1:0] nq  [4];
  logic signed [DATA_WIDTH-1:0] maxn, q_a;
  logic signed [CW-1:0]         maxe, qa, boot, rew, td, qn;
  logic [DATA_WIDTH-1:0]        qn_sat;

  // Off-grid moves leave the agent where it is.
  function automatic logic [STATE_WIDTH-1:0] move(input logic [STATE_WIDTH-1:0] s,
                                                  input logic [1:0] a);
    int p;
    p = int'(s);
    case (a)
      2'd0:    if (p >= GRID) p = p - GRID;
      2'd1:    if (p < NS - GRID) p = p + GRID;
      2'd2:    if (p % GRID != 0) p = p - 1;
      default: if (p % GRID != GRID - 1) p = p + 1;
    endcase
    return STATE_WIDTH'(p);
  endfunction

  always_comb begin
    best = 2'd0;
    for (int i = 1; i < 4; i++)
      if (q[i] > q[best]) best = 2'(i);
    fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    lfsr_nx = {lfsr[14:0], fb};
    sel_a   = (int'(lfsr_nx[7:0]) < EPSILON) ? lfsr_nx[9:8] : best;
    nxt_c   = move(cur_s, sel_a);
    rd_s    = (st == RD_CUR) ? cur_s : nxt_s;
    start_s = (i_step == '0) ? START_S : o_state;
    cap_idx = sub[1:0] - 2'd1;
  end

  // TD update in DATA_WIDTH+2 bits so intermediate sums cannot wrap before saturation.
  always_comb begin
    maxn = nq[0];
    for (int i = 1; i < 4; i++)
      if (nq[i] > maxn) maxn = nq[i];
    q_a  = q[act];
    maxe = {{2{maxn[DATA_WIDTH-1]}}, maxn};
    qa   = {{2{q_a[DATA_WIDTH-1]}}, q_a};
    boot = goal_r ? '0 : maxe - (maxe >>> GAMMA_SHIFT);
    rew  = goal_r ? RW_GOAL : RW_STEP;
    td   = rew + boot - qa;
    qn   = qa + (td >>> ALPHA_SHIFT);
    if (qn > QMAX)      qn_sat = QMAX[DATA_WIDTH-1:0];
    else if (qn < QMIN) qn_sat = QMIN[DATA_WIDTH-1:0];
    else                qn_sat = qn[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      sub         <= '0;
      cur_s       <= START_S;
      nxt_s       <= START_S;
      act         <= '0;
      goal_r      <= 1'b0;
      lfsr        <= LFSR_SEED;
      for (int i = 0; i < 4; i++) begin
        q[i]  <= '0;
        nq[i] <= '0;
      end
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_goal      <= 1'b0;
      o_state     <= START_S;
      o_mem_rd_en <= 1'b0;
      o_mem_wr_en <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      case (st)
        IDLE: if (i_valid) begin
          cur_s       <= start_s;
          o_state     <= start_s;
          o_busy      <= 1'b1;
          sub         <= '0;
          o_mem_rd_en <= 1'b1;
          o_mem_addr  <= {start_s, 2'd0};
          st          <= RD_CUR;
        end
        RD_CUR, RD_NEXT: begin
          // Read issued in sub-count k returns during k+1.
          if (sub != 3'd0) begin
            if (st == RD_CUR) q[cap_idx]  <= i_mem_rdata;
            else              nq[cap_idx] <= i_mem_rdata;
          end
          if (sub < 3'd3) begin
            o_mem_rd_en <= 1'b1;
            o_mem_addr  <= {rd_s, sub[1:0] + 2'd1};
          end else begin
            o_mem_rd_en <= 1'b0;
            o_mem_addr  <= '0;
          end
          if (sub == 3'd4) begin
            sub <= '0;
            st  <= (st == RD_CUR) ? SELECT : CALC;
          end else begin
            sub <= sub + 3'd1;
          end
        end
        SELECT: begin
          lfsr        <= lfsr_nx;
          act         <= sel_a;
          nxt_s       <= nxt_c;
          goal_r      <= (nxt_c == GOAL_S);
          o_mem_rd_en <= 1'b1;
          o_mem_addr  <= {nxt_c, 2'd0};
          st          <= RD_NEXT;
        end
        CALC: begin
          o_mem_wr_en <= 1'b1;
          o_mem_addr  <= {cur_s, act};
          o_mem_wdata <= qn_sat;
          st          <= WRITE;
        end
        WRITE: begin
          o_mem_wr_en <= 1'b0;
          o_mem_addr  <= '0;
          o_mem_wdata <= '0;
          o_valid     <= 1'b1;
          o_goal      <= goal_r;
          o_state     <= goal_r ? START_S : nxt_s;
          st          <= DONE;
        end
        DONE: begin
          o_valid <= 1'b0;
          o_goal  <= 1'b0;
          o_busy  <= 1'b0;
          st      <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
